// File: rtl/led_fade_driver_pkg.sv
// ----------------------------------------------------------------------------
// led_drv_pkg
// Shared definitions for the LED fade driver: the FSM state encoding (which is
// also visible on the state_o port) and a small decode helper.
// No ports; imported by tick_prescaler and led_fade_driver.
// ----------------------------------------------------------------------------
package led_drv_pkg;

    // Encoding is visible to software/debug through state_o, so keep it fixed.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } led_state_e;

    // True for the two states in which the duty is moving.
    function automatic logic is_ramping(input led_state_e s);
        return (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN);
    endfunction

endpackage

// File: rtl/led_fade_driver_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-clock ramp tick every DIV clocks.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   tick_o   out  high for one clock when the count is DIV-1
// ----------------------------------------------------------------------------
module tick_prescaler
    import led_drv_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

    // Decoded from the registered count, so the tick is glitch-free and
    // lines up with the wrap cycle.
    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/led_fade_driver.sv
// ----------------------------------------------------------------------------
// led_fade_driver
// Turns the 1-bit PIO LED request into a PWM LED drive that fades in, holds
// full brightness and fades out. Single clock domain.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   led_req_i  in   LED request level from the PIO (1 = on)
//   ramp_en_i  in   1 = fade ramps, 0 = duty jumps straight to MAX/0
//   led_o      out  registered PWM LED drive
//   duty_o     out  current duty value
//   busy_o     out  1 while ramping up or down
//   state_o    out  FSM state (0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN)
// ----------------------------------------------------------------------------
module led_fade_driver
    import led_drv_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                led_req_i,
    input  logic                ramp_en_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                busy_o,
    output logic [1:0]          state_o
);

    localparam int SW = PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [SW-1:0]       STEP_W = SW'(RAMP_STEP);

    logic                req_q;
    logic                tick;
    led_state_e          state_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                busy_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                led_q;
    logic                led_d;
    logic [SW-1:0]       up_sum;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;

    tick_prescaler #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_o  (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            req_q     <= led_req_i;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            led_q     <= led_d;
        end
    end

    // Saturating step in both directions; the add is done one bit wider so an
    // overshoot past MAX is caught instead of wrapping to a small duty.
    always_comb begin
        up_sum  = {1'b0, duty_q} + STEP_W;
        duty_up = (up_sum > {1'b0, MAX}) ? MAX : up_sum[PWM_BITS-1:0];
        duty_dn = ({1'b0, duty_q} > STEP_W) ? (duty_q - STEP_W[PWM_BITS-1:0]) : '0;
        // Full scale is forced high, otherwise the counter never exceeds MAX
        // and the LED would blink off once per period.
        led_d   = (duty_q == MAX) ? 1'b1 : (pwm_cnt_q < duty_q);
    end

    // A request reversal is checked before the tick, so a reversal that lands
    // on a tick cycle turns the ramp around without applying a step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_q) begin
                        if (ramp_en_i) begin
                            state_q <= ST_RAMP_UP;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_HOLD;
                            duty_q  <= MAX;
                        end
                    end
                end
                ST_RAMP_UP: begin
                    if (!req_q) begin
                        if (ramp_en_i) begin
                            state_q <= ST_RAMP_DOWN;
                        end else begin
                            state_q <= ST_IDLE;
                            duty_q  <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else if (!ramp_en_i) begin
                        state_q <= ST_HOLD;
                        duty_q  <= MAX;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        duty_q <= duty_up;
                        if (duty_up == MAX) begin
                            state_q <= ST_HOLD;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!req_q) begin
                        if (ramp_en_i) begin
                            state_q <= ST_RAMP_DOWN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            duty_q  <= '0;
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (req_q) begin
                        if (ramp_en_i) begin
                            state_q <= ST_RAMP_UP;
                        end else begin
                            state_q <= ST_HOLD;
                            duty_q  <= MAX;
                            busy_q  <= 1'b0;
                        end
                    end else if (!ramp_en_i) begin
                        state_q <= ST_IDLE;
                        duty_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        duty_q <= duty_dn;
                        if (duty_dn == '0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    duty_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_o   = led_q;
    assign duty_o  = duty_q;
    assign busy_o  = busy_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// ----------------------------------------------------------------------------
// tb_led_fade_driver
// Self-checking bench for led_fade_driver. Two instances share the stimulus:
// dut0 with RAMP_STEP=1 and dut1 with RAMP_STEP=4 (saturation case). A
// behavioural model described in terms of "target level, direction, tick
// every DIV clocks, PWM phase = cycle mod 16" predicts every output of both
// instances each clock.
// ----------------------------------------------------------------------------
module tb_led_fade_driver;

    localparam int DIV  = 4;
    localparam int MAXV = 15;
    localparam int S_IDLE = 0, S_UP = 1, S_HOLD = 2, S_DOWN = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ledReq = 1'b0;
    logic       rampEn = 1'b1;
    logic       led0, led1, busy0, busy1;
    logic [3:0] duty0, duty1;
    logic [1:0] state0, state1;

    int checks = 0;
    int failures = 0;

    // Reference model state, one entry per instance
    int mDuty[2];
    int mState[2];
    int mBusy[2];
    int mLed[2];
    int stepSize[2] = '{1, 4};
    int mReq;
    int mCycles;

    // 10 time-unit clock
    always #5 clk = ~clk;

    led_fade_driver #(.TICK_DIV(DIV), .PWM_BITS(4), .RAMP_STEP(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .led_req_i(ledReq), .ramp_en_i(rampEn),
        .led_o(led0), .duty_o(duty0), .busy_o(busy0), .state_o(state0)
    );

    led_fade_driver #(.TICK_DIV(DIV), .PWM_BITS(4), .RAMP_STEP(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .led_req_i(ledReq), .ramp_en_i(rampEn),
        .led_o(led1), .duty_o(duty1), .busy_o(busy1), .state_o(state1)
    );

    // Single comparison point: counts every check, reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Model view of reset: everything back to zero, cycle count restarts
    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mDuty[k] = 0; mState[k] = S_IDLE; mBusy[k] = 0; mLed[k] = 0;
        end
        mReq = 0;
        mCycles = 0;
    endtask

    // Advance the model by one clock edge using the pre-edge values.
    // Without ramping the duty simply sits at the level the request asks for;
    // with ramping it moves toward that level one step per tick, and a change
    // of mind only flips the direction for that cycle.
    task automatic modelStep();
        bit tick;
        int pwm;
        tick = ((mCycles % DIV) == DIV - 1);
        pwm  = mCycles % (MAXV + 1);
        for (int k = 0; k < 2; k++) begin
            int d;
            int s;
            bit goingUp;
            d = mDuty[k];
            s = mState[k];
            mLed[k] = (d == MAXV) ? 1 : ((pwm < d) ? 1 : 0);
            if (!rampEn) begin
                s = (mReq != 0) ? S_HOLD : S_IDLE;
                d = (mReq != 0) ? MAXV : 0;
            end else if (s == S_IDLE || s == S_HOLD) begin
                if (mReq != 0 && s == S_IDLE) s = S_UP;
                else if (mReq == 0 && s == S_HOLD) s = S_DOWN;
            end else begin
                goingUp = (s == S_UP);
                if ((mReq != 0) != goingUp) begin
                    s = (mReq != 0) ? S_UP : S_DOWN;
                end else if (tick) begin
                    d = goingUp ? d + stepSize[k] : d - stepSize[k];
                    if (d > MAXV) d = MAXV;
                    if (d < 0) d = 0;
                    if (goingUp && d == MAXV) s = S_HOLD;
                    if (!goingUp && d == 0) s = S_IDLE;
                end
            end
            mDuty[k]  = d;
            mState[k] = s;
            mBusy[k]  = (s == S_UP || s == S_DOWN) ? 1 : 0;
        end
        mReq = ledReq;
        mCycles++;
    endtask

    task automatic compareAll();
        checkOutput("state0", state0, mState[0]);
        checkOutput("duty0",  duty0,  mDuty[0]);
        checkOutput("busy0",  busy0,  mBusy[0]);
        checkOutput("led0",   led0,   mLed[0]);
        checkOutput("state1", state1, mState[1]);
        checkOutput("duty1",  duty1,  mDuty[1]);
        checkOutput("busy1",  busy1,  mBusy[1]);
        checkOutput("led1",   led1,   mLed[1]);
    endtask

    // Drive inputs at the falling edge, run n clocks, check each at the next falling edge
    task automatic applyStimulus(input logic req, input logic en, input int n);
        ledReq = req;
        rampEn = en;
        repeat (n) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            compareAll();
        end
    endtask

    initial begin
        int count;
        int prevDuty1;
        int sawSat;
        int guard;

        // Initial reset, released at a falling edge
        modelReset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        compareAll();

        // Rise with ramping: two-clock latency into RAMP_UP
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("riseLatency1", state0, S_IDLE);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("riseLatency2", state0, S_UP);

        // Ramp to HOLD; watch dut1 (step 4) saturate at 12 -> 15
        sawSat = 0;
        prevDuty1 = duty1;
        guard = 0;
        while (state0 != S_HOLD && guard < 200) begin
            applyStimulus(1'b1, 1'b1, 1);
            if (prevDuty1 == 12 && duty1 != 12) begin
                checkOutput("step4Sat", duty1, 15);
                sawSat = 1;
            end
            prevDuty1 = duty1;
            guard++;
        end
        checkOutput("holdReached", state0, S_HOLD);
        checkOutput("holdBusy", busy0, 0);
        checkOutput("holdDuty", duty0, MAXV);
        checkOutput("sawStep4Sat", sawSat, 1);
        applyStimulus(1'b1, 1'b1, 1);
        count = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1);
            count += led0;
        end
        checkOutput("holdLedOn", count, 16);

        // Fall to IDLE
        guard = 0;
        while (state0 != S_IDLE && guard < 200) begin
            applyStimulus(1'b0, 1'b1, 1);
            if (state0 == S_DOWN) checkOutput("fallBusy", busy0, 1);
            guard++;
        end
        checkOutput("idleReached", state0, S_IDLE);
        checkOutput("idleDuty", duty0, 0);
        applyStimulus(1'b0, 1'b1, 1);
        count = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            count += led0;
        end
        checkOutput("idleLedOff", count, 0);

        // Reversal at duty 6 on the way up, and back at duty 3 on the way down
        guard = 0;
        while (duty0 != 6 && guard < 100) begin
            applyStimulus(1'b1, 1'b1, 1);
            guard++;
        end
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("revDownState", state0, S_DOWN);
        checkOutput("revDownDuty", duty0, 6);
        guard = 0;
        while (duty0 != 3 && guard < 100) begin
            applyStimulus(1'b0, 1'b1, 1);
            guard++;
        end
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("revUpState", state0, S_UP);
        checkOutput("revUpDuty", duty0, 3);
        guard = 0;
        while (duty0 == 3 && guard < 20) begin
            applyStimulus(1'b1, 1'b1, 1);
            guard++;
        end
        checkOutput("revUpNext", duty0, 4);

        // Freeze duty at 5 by reversing every clock, then measure PWM
        guard = 0;
        while (duty0 != 5 && guard < 100) begin
            applyStimulus(1'b1, 1'b1, 1);
            guard++;
        end
        count = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus((i % 2) == 1, 1'b1, 1);
            if (i >= 16) count += led0;
        end
        checkOutput("frozenDuty", duty0, 5);
        checkOutput("pwmDuty5", count, 5);

        // No ramping: jump straight to HOLD and back to IDLE
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("jumpStartIdle", state0, S_IDLE);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("jumpOnLatency", state0, S_IDLE);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("jumpOnState", state0, S_HOLD);
        checkOutput("jumpOnDuty", duty0, MAXV);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("jumpOffState", state0, S_IDLE);
        checkOutput("jumpOffDuty", duty0, 0);

        // Asynchronous reset in the middle of a ramp, checked before the next edge
        applyStimulus(1'b1, 1'b1, 14);
        @(posedge clk);
        modelStep();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncRstLed", led0, 0);
        checkOutput("asyncRstDuty", duty0, 0);
        checkOutput("asyncRstState", state0, S_IDLE);
        checkOutput("asyncRstBusy", busy0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("restartAfterRst", state0, S_UP);

        // Randomized phase
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(1, 40)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
